// File: rtl/reg_write_sequencer.sv
// rtl/reg_write_sequencer.sv - write-side master for a bank of capture registers
// Arm-then-fire strobe per register, valid-flag confirmation with bounded retry.
module reg_write_sequencer #(
  parameter int NUM_REGS  = 4,
  parameter int SETUP_CYC = 1,
  parameter int MAX_RETRY = 2
) (
  input  logic                    clock,
  input  logic                    rst_n,
  input  logic                    wr_req,
  input  logic [1:0]              wr_addr,
  input  logic [3:0]              wr_data,
  input  logic [NUM_REGS-1:0]     valid_in,
  output logic                    busy,
  output logic                    wr_ack,
  output logic                    wr_err,
  output logic [3:0]              data_bus,
  output logic [3*NUM_REGS-1:0]   cap_bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    FIRE  = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4,
    ERR   = 3'd5
  } state_t;

  localparam int SCW = (SETUP_CYC > 1) ? $clog2(SETUP_CYC) : 1;
  localparam logic [SCW-1:0] SETUP_LAST = SCW'(SETUP_CYC - 1);
  localparam logic [2:0]     RETRY_MAX  = 3'(MAX_RETRY);
  localparam logic [2:0]     ARM_PAT    = 3'b110;
  localparam logic [2:0]     FIRE_PAT   = 3'b111;

  state_t          state;
  logic [1:0]      addr_q;
  logic [3:0]      data_q;
  logic [2:0]      retry_cnt;
  logic [SCW-1:0]  setup_cnt;
  logic [3:0]      valid_pad;
  logic            addr_legal;

  // Pad the flags to the full address range so any 2-bit index is in bounds.
  always_comb begin
    valid_pad = '0;
    valid_pad[NUM_REGS-1:0] = valid_in;
  end

  assign addr_legal = ({1'b0, wr_addr} < 3'(NUM_REGS));

  function automatic logic [3*NUM_REGS-1:0] slice_pat(input logic [1:0] a, input logic [2:0] p);
    logic [3*NUM_REGS-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (a == 2'(i)) v[3*i +: 3] = p;
    end
    return v;
  endfunction

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      wr_ack    <= 1'b0;
      wr_err    <= 1'b0;
      data_bus  <= '0;
      cap_bus   <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      retry_cnt <= '0;
      setup_cnt <= '0;
    end else begin
      wr_ack <= 1'b0;
      wr_err <= 1'b0;
      case (state)
        IDLE: begin
          busy    <= 1'b0;
          cap_bus <= '0;
          if (wr_req) begin
            addr_q    <= wr_addr;
            data_q    <= wr_data;
            retry_cnt <= '0;
            busy      <= 1'b1;
            if (addr_legal) begin
              state     <= SETUP;
              setup_cnt <= '0;
              data_bus  <= wr_data;
              cap_bus   <= slice_pat(wr_addr, ARM_PAT);
            end else begin
              state  <= ERR;
              wr_err <= 1'b1;
            end
          end
        end
        SETUP: begin
          if (setup_cnt == SETUP_LAST) begin
            state   <= FIRE;
            cap_bus <= slice_pat(addr_q, FIRE_PAT);
          end else begin
            setup_cnt <= setup_cnt + 1'b1;
          end
        end
        FIRE: begin
          state   <= CHECK;
          cap_bus <= '0;
        end
        CHECK: begin
          if (valid_pad[addr_q]) begin
            state  <= DONE;
            wr_ack <= 1'b1;
          end else if (retry_cnt < RETRY_MAX) begin
            // Re-arm from the latched copy so a retry never depends on live inputs.
            retry_cnt <= retry_cnt + 1'b1;
            state     <= SETUP;
            setup_cnt <= '0;
            data_bus  <= data_q;
            cap_bus   <= slice_pat(addr_q, ARM_PAT);
          end else begin
            state  <= ERR;
            wr_err <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        ERR: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          busy    <= 1'b0;
          cap_bus <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_write_sequencer.sv
// tb/tb_reg_write_sequencer.sv - directed self-checking bench for reg_write_sequencer
// Checks are made on the falling edge, inputs change on the falling edge.
module tb_reg_write_sequencer;

  logic        clock = 1'b0;
  logic        rst_n;
  logic        wr_req, wr_req3;
  logic [1:0]  wr_addr;
  logic [3:0]  wr_data;
  logic [3:0]  valid_in;
  logic        busy, wr_ack, wr_err;
  logic [3:0]  data_bus;
  logic [11:0] cap_bus;
  logic        busy3, wr_ack3, wr_err3;
  logic [3:0]  data_bus3;
  logic [8:0]  cap_bus3;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  reg_write_sequencer #(.NUM_REGS(4), .SETUP_CYC(1), .MAX_RETRY(2)) dut (
    .clock(clock), .rst_n(rst_n), .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
    .valid_in(valid_in), .busy(busy), .wr_ack(wr_ack), .wr_err(wr_err),
    .data_bus(data_bus), .cap_bus(cap_bus)
  );

  reg_write_sequencer #(.NUM_REGS(3), .SETUP_CYC(1), .MAX_RETRY(2)) dut3 (
    .clock(clock), .rst_n(rst_n), .wr_req(wr_req3), .wr_addr(wr_addr), .wr_data(wr_data),
    .valid_in(valid_in[2:0]), .busy(busy3), .wr_ack(wr_ack3), .wr_err(wr_err3),
    .data_bus(data_bus3), .cap_bus(cap_bus3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clock);
  endtask

  // {busy, ack, err, data_bus, cap_bus} of the 4-register instance
  task automatic chk4(input string tag, input logic b, input logic a, input logic e,
                      input logic [3:0] d, input logic [11:0] c);
    chk({tag, ".busy"}, 32'(busy), 32'(b));
    chk({tag, ".ack"},  32'(wr_ack), 32'(a));
    chk({tag, ".err"},  32'(wr_err), 32'(e));
    chk({tag, ".data"}, 32'(data_bus), 32'(d));
    chk({tag, ".cap"},  32'(cap_bus), 32'(c));
  endtask

  initial begin
    rst_n = 1'b0; wr_req = 1'b0; wr_req3 = 1'b0;
    wr_addr = '0; wr_data = '0; valid_in = '0;
    step(); step();
    chk4("reset", 0, 0, 0, 4'h0, 12'h000);
    chk("reset.busy3", 32'(busy3), 32'd0);
    chk("reset.cap3", 32'(cap_bus3), 32'd0);
    rst_n = 1'b1;
    step();

    // 1: addr 2, data A, first-try success
    wr_req = 1'b1; wr_addr = 2'd2; wr_data = 4'hA;
    step();
    wr_req = 1'b0;
    chk4("t1.setup", 1, 0, 0, 4'hA, 12'h180);
    step();
    chk4("t1.fire", 1, 0, 0, 4'hA, 12'h1C0);
    valid_in = 4'b0100;
    step();
    chk4("t1.check", 1, 0, 0, 4'hA, 12'h000);
    step();
    chk4("t1.done", 1, 1, 0, 4'hA, 12'h000);
    step();
    chk4("t1.idle", 0, 0, 0, 4'hA, 12'h000);
    valid_in = 4'b0000;

    // 2: addr 1 never confirms -> three passes then error
    wr_req = 1'b1; wr_addr = 2'd1; wr_data = 4'h3;
    step();
    wr_req = 1'b0;
    for (int p = 0; p < 3; p++) begin
      chk4($sformatf("t2.setup%0d", p), 1, 0, 0, 4'h3, 12'h030);
      step();
      chk4($sformatf("t2.fire%0d", p), 1, 0, 0, 4'h3, 12'h038);
      step();
      chk4($sformatf("t2.check%0d", p), 1, 0, 0, 4'h3, 12'h000);
      step();
    end
    chk4("t2.err", 1, 0, 1, 4'h3, 12'h000);
    step();
    chk4("t2.idle", 0, 0, 0, 4'h3, 12'h000);

    // 3: addr 0 confirms on the second check
    wr_req = 1'b1; wr_addr = 2'd0; wr_data = 4'h5;
    step();
    wr_req = 1'b0;
    chk4("t3.setup0", 1, 0, 0, 4'h5, 12'h006);
    step();
    chk4("t3.fire0", 1, 0, 0, 4'h5, 12'h007);
    step();
    chk4("t3.check0", 1, 0, 0, 4'h5, 12'h000);
    step();
    valid_in = 4'b0001;
    chk4("t3.setup1", 1, 0, 0, 4'h5, 12'h006);
    step();
    chk4("t3.fire1", 1, 0, 0, 4'h5, 12'h007);
    step();
    chk4("t3.check1", 1, 0, 0, 4'h5, 12'h000);
    step();
    chk4("t3.done", 1, 1, 0, 4'h5, 12'h000);
    step();
    chk4("t3.idle", 0, 0, 0, 4'h5, 12'h000);
    valid_in = 4'b0000;

    // 4: NUM_REGS=3, illegal addr 3
    wr_req3 = 1'b1; wr_addr = 2'd3; wr_data = 4'hF;
    step();
    wr_req3 = 1'b0;
    chk("t4.err3", 32'(wr_err3), 32'd1);
    chk("t4.busy3", 32'(busy3), 32'd1);
    chk("t4.ack3", 32'(wr_ack3), 32'd0);
    chk("t4.cap3a", 32'(cap_bus3), 32'd0);
    chk("t4.idle4", 32'(busy), 32'd0);
    step();
    chk("t4.err3_off", 32'(wr_err3), 32'd0);
    chk("t4.busy3_off", 32'(busy3), 32'd0);
    chk("t4.cap3b", 32'(cap_bus3), 32'd0);

    // 5: request during a busy write is ignored
    valid_in = 4'b1000;
    wr_req = 1'b1; wr_addr = 2'd3; wr_data = 4'hC;
    step();
    wr_addr = 2'd0; wr_data = 4'h5;
    chk4("t5.setup", 1, 0, 0, 4'hC, 12'hC00);
    step();
    chk4("t5.fire", 1, 0, 0, 4'hC, 12'hE00);
    step();
    chk4("t5.check", 1, 0, 0, 4'hC, 12'h000);
    step();
    chk4("t5.done", 1, 1, 0, 4'hC, 12'h000);
    wr_req = 1'b0;
    step();
    chk4("t5.idle", 0, 0, 0, 4'hC, 12'h000);
    step();
    chk4("t5.idle2", 0, 0, 0, 4'hC, 12'h000);
    valid_in = 4'b0000;

    // 6: reset during FIRE aborts, then a fresh write completes
    wr_req = 1'b1; wr_addr = 2'd2; wr_data = 4'h6;
    step();
    wr_req = 1'b0;
    chk4("t6.setup", 1, 0, 0, 4'h6, 12'h180);
    step();
    chk4("t6.fire", 1, 0, 0, 4'h6, 12'h1C0);
    rst_n = 1'b0;
    #1;
    chk4("t6.rst", 0, 0, 0, 4'h0, 12'h000);
    step();
    rst_n = 1'b1;
    step();
    chk4("t6.after1", 0, 0, 0, 4'h0, 12'h000);
    step();
    chk4("t6.after2", 0, 0, 0, 4'h0, 12'h000);
    valid_in = 4'b0010;
    wr_req = 1'b1; wr_addr = 2'd1; wr_data = 4'h9;
    step();
    wr_req = 1'b0;
    chk4("t6.setup2", 1, 0, 0, 4'h9, 12'h030);
    step();
    chk4("t6.fire2", 1, 0, 0, 4'h9, 12'h038);
    step();
    chk4("t6.check2", 1, 0, 0, 4'h9, 12'h000);
    step();
    chk4("t6.done2", 1, 1, 0, 4'h9, 12'h000);
    step();
    chk4("t6.idle2", 0, 0, 0, 4'h9, 12'h000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_write_sequencer.md
Name: reg_write_sequencer

Overview:
Write-side master for a bank of capture registers. Each register loads its 4-bit data input and sets its valid flag only when all three bits of its capture field are 1.
The sequencer accepts write requests over a req/ack handshake and drives the shared data bus and one 3-bit capture field per register. It strobes the target register with a glitch-free arm-then-fire sequence, then confirms the write by checking that register's valid flag, retrying on failure.
It sits between the control logic and the register bank.

Parameters:
NUM_REGS, 4, number of target registers (1..4); wr_addr values >= NUM_REGS are illegal
SETUP_CYC, 1, cycles (>=1) data_bus and the arm pattern are held before the fire cycle
MAX_RETRY, 2, extra attempts (0..7) after a failed valid check before signalling error

Ports:
clock  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
wr_req  input  1  write request, sampled only when busy=0
wr_addr  input  2  target register index
wr_data  input  4  value to write
valid_in  input  NUM_REGS  valid flags returned from the register bank, bit i = register i
busy  output  1  high from the cycle after an accepted request until the return to IDLE
wr_ack  output  1  one-cycle pulse: write confirmed
wr_err  output  1  one-cycle pulse: write failed or illegal address
data_bus  output  4  data driven to all registers' data inputs
cap_bus  output  3*NUM_REGS  capture fields, slice [3i+2:3i] belongs to register i

Behaviour:
- Reset (asynchronous, any state): state=IDLE, busy=0, wr_ack=0, wr_err=0, data_bus=0, cap_bus=0, retry count=0, latched addr/data=0. Reset during SETUP or FIRE aborts the sequence; no ack or err is produced.
- States: IDLE, SETUP, FIRE, CHECK, DONE, ERR. All outputs are registered or decoded from state only; no combinational path from any input to any output.
- IDLE:
  - busy=0, cap_bus=0, data_bus holds its last driven value.
  - wr_req=1 -> latch wr_addr/wr_data, clear retry count.
  - If addr < NUM_REGS -> SETUP; else -> ERR.
- SETUP:
  - busy=1, data_bus=latched data, target slice=3'b110, all other slices 0.
  - Lasts exactly SETUP_CYC cycles, then -> FIRE.
- FIRE (1 cycle): target slice=3'b111, data_bus unchanged. The register captures at the end of this cycle. -> CHECK.
- CHECK (1 cycle): cap_bus=0, data_bus held. Sample valid_in[addr].
  - 1 -> DONE.
  - 0 and retry count < MAX_RETRY -> increment count, -> SETUP.
  - 0 and count == MAX_RETRY -> ERR.
- DONE: wr_ack=1 for one cycle, -> IDLE.
- ERR: wr_err=1 for one cycle, -> IDLE.
- busy is 1 in SETUP, FIRE, CHECK, DONE and ERR.
- wr_req while busy=1 is ignored (no queue); the requester must hold or reissue it.
- wr_ack and wr_err are never asserted together.
- Back-to-back writes: wr_req seen in the IDLE cycle after DONE is accepted. Minimum request spacing is SETUP_CYC+4 cycles.
- Latency, SETUP_CYC=1, success first try, req sampled at edge n:
  - SETUP in cycle n+1
  - FIRE in cycle n+2
  - CHECK in cycle n+3
  - wr_ack high in cycle n+4

Test Plan:
1. Reset, then wr_req with addr=2, data=4'hA, valid_in[2] rising after FIRE -> slice 2 = 110 then 111, data_bus=A, wr_ack in cycle n+4, cap_bus=0 afterwards.
2. valid_in[1] held 0, MAX_RETRY=2, write to addr=1 -> three SETUP/FIRE/CHECK passes, then wr_err pulse, no wr_ack.
3. valid_in[0] 0 on first CHECK and 1 on second, write to addr=0 -> exactly one retry, wr_ack on the cycle after the second CHECK.
4. NUM_REGS=3, wr_addr=3 -> cap_bus never nonzero, wr_err on the cycle after acceptance.
5. Second wr_req (addr=0, data=5) asserted during a busy write to addr=3 -> ignored; only addr 3 is strobed, single ack.
6. rst_n low during FIRE -> all outputs 0 immediately; after release, state IDLE, no ack/err; a new write completes normally.
